// File: rtl/alu_ctrl_fsm_pkg.sv
`default_nettype none
// ============================================================================
// Module      : alu_ctrl_fsm_pkg
// Description : Shared definitions for the execute-stage control unit:
//               FSM state codes, opcode/funct constants, ALU op codes and
//               the instruction class enumeration. The ALU imports the same
//               ALU op codes.
// Revision    : 1.0 - initial release
// ============================================================================
package alu_ctrl_fsm_pkg;

    // Control FSM states
    localparam logic [2:0] ST_FETCH  = 3'd0;
    localparam logic [2:0] ST_DECODE = 3'd1;
    localparam logic [2:0] ST_EXEC   = 3'd2;
    localparam logic [2:0] ST_MEM    = 3'd3;
    localparam logic [2:0] ST_WB     = 3'd4;

    // Primary opcodes (instr[31:26])
    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;
    localparam logic [5:0] OP_BEQ   = 6'h04;

    // R-type function codes (instr[5:0])
    localparam logic [5:0] FN_ADD = 6'h20;
    localparam logic [5:0] FN_SUB = 6'h22;
    localparam logic [5:0] FN_AND = 6'h24;
    localparam logic [5:0] FN_XOR = 6'h26;

    // ALU operation select
    localparam logic [1:0] ALU_ADD = 2'd0;
    localparam logic [1:0] ALU_SUB = 2'd1;
    localparam logic [1:0] ALU_AND = 2'd2;
    localparam logic [1:0] ALU_XOR = 2'd3;

    typedef enum logic [2:0] {
        CLS_RTYPE = 3'd0,
        CLS_ADDI  = 3'd1,
        CLS_LW    = 3'd2,
        CLS_SW    = 3'd3,
        CLS_BEQ   = 3'd4
    } instr_class_e;

endpackage : alu_ctrl_fsm_pkg
`default_nettype wire

// File: rtl/alu_ctrl_fsm_instr_decoder.sv
`default_nettype none
// ============================================================================
// Module      : instr_decoder
// Description : Combinational decode of opcode/funct into an instruction
//               class, the ALU operation and an illegal flag.
// Ports       : i_opcode [5:0]  primary opcode
//               i_funct  [5:0]  R-type function field
//               o_cls           instruction class
//               o_alu_op [1:0]  ALU operation for the EXEC cycle
//               o_illegal       opcode/funct combination is not supported
// Revision    : 1.0 - initial release
// ============================================================================
module instr_decoder
    import alu_ctrl_fsm_pkg::*;
(
    input  logic [5:0]   i_opcode,
    input  logic [5:0]   i_funct,
    output instr_class_e o_cls,
    output logic [1:0]   o_alu_op,
    output logic         o_illegal
);

    always_comb begin
        o_cls     = CLS_RTYPE;
        o_alu_op  = ALU_ADD;
        o_illegal = 1'b0;
        case (i_opcode)
            OP_RTYPE: begin
                o_cls = CLS_RTYPE;
                case (i_funct)
                    FN_ADD:  o_alu_op = ALU_ADD;
                    FN_SUB:  o_alu_op = ALU_SUB;
                    FN_AND:  o_alu_op = ALU_AND;
                    FN_XOR:  o_alu_op = ALU_XOR;
                    default: o_illegal = 1'b1;
                endcase
            end
            OP_ADDI: o_cls = CLS_ADDI;
            OP_LW:   o_cls = CLS_LW;
            OP_SW:   o_cls = CLS_SW;
            OP_BEQ: begin
                // Branch compare is a subtraction; the ALU flags equality
                o_cls    = CLS_BEQ;
                o_alu_op = ALU_SUB;
            end
            default: o_illegal = 1'b1;
        endcase
    end

endmodule : instr_decoder
`default_nettype wire

// File: rtl/alu_ctrl_fsm.sv
`default_nettype none
// ============================================================================
// Module      : alu_ctrl_fsm
// Description : Multi-cycle control unit for the execute-stage ALU. Fetches
//               over a req/ack memory handshake, decodes, and sequences
//               EXEC / MEM / WB. Counts retired instructions.
// Ports       : clk, rst (async, active-high)
//               instr, mem_ack, beq_in_1            - inputs
//               mem_req, mem_we, ir_load, pc_en, pc_src,
//               alu_op_ctrl, alu_ctrl, beq_inst, alu_src_imm, reg_dst,
//               mem_to_reg, reg_we, illegal, instr_count - outputs
// Revision    : 1.0 - initial release
// ============================================================================
module alu_ctrl_fsm
    import alu_ctrl_fsm_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int CNT_W  = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] instr,
    input  logic              mem_ack,
    input  logic              beq_in_1,
    output logic              mem_req,
    output logic              mem_we,
    output logic              ir_load,
    output logic              pc_en,
    output logic              pc_src,
    output logic [1:0]        alu_op_ctrl,
    output logic              alu_ctrl,
    output logic              beq_inst,
    output logic              alu_src_imm,
    output logic              reg_dst,
    output logic              mem_to_reg,
    output logic              reg_we,
    output logic              illegal,
    output logic [CNT_W-1:0]  instr_count
);

    logic [2:0]       state_q,  state_d;
    logic [5:0]       opcode_q, opcode_d;
    logic [5:0]       funct_q,  funct_d;
    logic [CNT_W-1:0] count_q,  count_d;

    instr_class_e     w_cls;
    logic [1:0]       w_alu_op;
    logic             w_dec_illegal;

    logic w_mem_req, w_mem_we, w_ir_load, w_pc_en, w_pc_src, w_alu_ctrl;
    logic w_beq_inst, w_alu_src_imm, w_reg_dst, w_mem_to_reg, w_reg_we;
    logic w_illegal;
    logic [1:0] w_alu_op_ctrl;

    // Only opcode and funct fields matter to this block
    logic w_unused_bits;
    assign w_unused_bits = &{1'b0, instr[25:6]};

    // Decode always works from the latched fields, never from live instr
    instr_decoder u_dec (
        .i_opcode  (opcode_q),
        .i_funct   (funct_q),
        .o_cls     (w_cls),
        .o_alu_op  (w_alu_op),
        .o_illegal (w_dec_illegal)
    );

    always_comb begin
        state_d       = state_q;
        opcode_d      = opcode_q;
        funct_d       = funct_q;
        count_d       = count_q;
        w_mem_req     = 1'b0;
        w_mem_we      = 1'b0;
        w_ir_load     = 1'b0;
        w_pc_en       = 1'b0;
        w_pc_src      = 1'b0;
        w_alu_op_ctrl = ALU_ADD;
        w_alu_ctrl    = 1'b0;
        w_beq_inst    = 1'b0;
        w_alu_src_imm = 1'b0;
        w_reg_dst     = 1'b0;
        w_mem_to_reg  = 1'b0;
        w_reg_we      = 1'b0;
        w_illegal     = 1'b0;

        case (state_q)
            ST_FETCH: begin
                w_mem_req = 1'b1;
                if (mem_ack) begin
                    w_ir_load = 1'b1;
                    w_pc_en   = 1'b1;
                    opcode_d  = instr[31:26];
                    funct_d   = instr[5:0];
                    state_d   = ST_DECODE;
                end
            end
            ST_DECODE: begin
                if (w_dec_illegal) begin
                    w_illegal = 1'b1;
                    state_d   = ST_FETCH;
                end else begin
                    state_d   = ST_EXEC;
                end
            end
            ST_EXEC: begin
                w_alu_ctrl    = 1'b1;
                w_alu_op_ctrl = w_alu_op;
                case (w_cls)
                    CLS_RTYPE: state_d = ST_WB;
                    CLS_ADDI: begin
                        w_alu_src_imm = 1'b1;
                        state_d       = ST_WB;
                    end
                    CLS_LW, CLS_SW: begin
                        w_alu_src_imm = 1'b1;
                        state_d       = ST_MEM;
                    end
                    CLS_BEQ: begin
                        w_beq_inst = 1'b1;
                        // Branch taken only when the ALU reports equality now
                        w_pc_en    = beq_in_1;
                        w_pc_src   = beq_in_1;
                        count_d    = count_q + CNT_W'(1);
                        state_d    = ST_FETCH;
                    end
                    default: state_d = ST_FETCH;
                endcase
            end
            ST_MEM: begin
                w_mem_req = 1'b1;
                w_mem_we  = (w_cls == CLS_SW);
                if (mem_ack) begin
                    if (w_cls == CLS_SW) begin
                        count_d = count_q + CNT_W'(1);
                        state_d = ST_FETCH;
                    end else begin
                        state_d = ST_WB;
                    end
                end
            end
            ST_WB: begin
                w_reg_we     = 1'b1;
                w_reg_dst    = (w_cls == CLS_RTYPE);
                w_mem_to_reg = (w_cls == CLS_LW);
                count_d      = count_q + CNT_W'(1);
                state_d      = ST_FETCH;
            end
            default: state_d = ST_FETCH;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= ST_FETCH;
            opcode_q <= 6'd0;
            funct_q  <= 6'd0;
            count_q  <= '0;
        end else begin
            state_q  <= state_d;
            opcode_q <= opcode_d;
            funct_q  <= funct_d;
            count_q  <= count_d;
        end
    end

    // The reset state is FETCH, whose Moore outputs would request memory;
    // masking with rst keeps every output quiet while reset is held and
    // drops an in-flight request the instant reset rises.
    assign mem_req     = w_mem_req     & ~rst;
    assign mem_we      = w_mem_we      & ~rst;
    assign ir_load     = w_ir_load     & ~rst;
    assign pc_en       = w_pc_en       & ~rst;
    assign pc_src      = w_pc_src      & ~rst;
    assign alu_op_ctrl = rst ? ALU_ADD : w_alu_op_ctrl;
    assign alu_ctrl    = w_alu_ctrl    & ~rst;
    assign beq_inst    = w_beq_inst    & ~rst;
    assign alu_src_imm = w_alu_src_imm & ~rst;
    assign reg_dst     = w_reg_dst     & ~rst;
    assign mem_to_reg  = w_mem_to_reg  & ~rst;
    assign reg_we      = w_reg_we      & ~rst;
    assign illegal     = w_illegal     & ~rst;
    assign instr_count = count_q;

endmodule : alu_ctrl_fsm
`default_nettype wire
